// File: rtl/my_dmux8way16_buf.sv
// Buffered 8-way demultiplexer: steers each accepted bus word into one of eight
// holding registers and keeps it flagged valid until that channel's consumer acks it.
module my_dmux8way16_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ack,
    output logic [3:0]       count
);

    logic [WIDTH-1:0] data_q [8];
    logic [7:0]       load;
    logic [7:0]       valid_d;
    logic [3:0]       count_d;

    // A full channel can still accept when its consumer drains it this same cycle.
    assign in_ready = ~out_valid[in_sel] | out_ack[in_sel];

    always_comb begin
        load = '0;
        if (in_valid && in_ready) begin
            load[in_sel] = 1'b1;
        end
        valid_d = load | (out_valid & ~out_ack);
        count_d = '0;
        for (int i = 0; i < 8; i++) begin
            count_d = count_d + {3'b000, valid_d[i]};
        end
    end

    // Data registers are only written on a load, so an acked word stays visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
            out_valid <= '0;
            count     <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (load[i]) begin
                    data_q[i] <= in_data;
                end
            end
            out_valid <= valid_d;
            count     <= count_d;
        end
    end

    assign out0 = data_q[0];
    assign out1 = data_q[1];
    assign out2 = data_q[2];
    assign out3 = data_q[3];
    assign out4 = data_q[4];
    assign out5 = data_q[5];
    assign out6 = data_q[6];
    assign out7 = data_q[7];

endmodule

// File: tb/tb_my_dmux8way16_buf.sv
// Self-checking bench for my_dmux8way16_buf: per-channel word queues act as the
// reference model; a monitor pops and compares whenever a consumer takes a word.
module tb_my_dmux8way16_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_sel;
    logic [15:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0]  out_valid;
    logic [7:0]  out_ack;
    logic [3:0]  count;

    logic [15:0] outs [8];

    int n_checks = 0;
    int n_fail   = 0;

    // Words delivered to each channel and not yet taken by its consumer.
    logic [15:0] sb [8][$];
    int          push_ch = -1;
    bit          mon_en  = 1'b0;

    my_dmux8way16_buf #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7),
        .out_valid(out_valid), .out_ack(out_ack), .count(count)
    );

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign outs[4] = out4;
    assign outs[5] = out5;
    assign outs[6] = out6;
    assign outs[7] = out7;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs; a word the producer knows will be accepted goes to the queue now.
    task automatic applyStimulus(input bit v, input logic [2:0] sel, input logic [15:0] data,
                                 input logic [7:0] ack);
        @(negedge clk);
        #1;
        in_valid = v;
        in_sel   = sel;
        in_data  = data;
        out_ack  = ack;
        push_ch  = -1;
        if (!reset && v && (sb[sel].size() == 0 || ack[sel])) begin
            sb[sel].push_back(data);
            push_ch = int'(sel);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 3'd0, 16'h0000, 8'h00);
        #2;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'h0);
        checkOutput({tag, "_count"}, 32'(count), 32'h0);
        for (int n = 0; n < 8; n++) begin
            checkOutput($sformatf("%s_out%0d", tag, n), 32'(outs[n]), 32'h0);
        end
    endtask

    task automatic clearModel();
        for (int n = 0; n < 8; n++) begin
            sb[n].delete();
        end
        push_ch = -1;
    endtask

    // Monitor: samples just before each rising edge, compares against the queues, pops on consumption.
    initial begin : monitor
        logic [7:0] exp_valid;
        int         exp_cnt;
        int         occ;
        logic       exp_ready;
        forever begin
            @(negedge clk);
            #4;
            if (mon_en && !reset) begin
                exp_valid = '0;
                exp_cnt   = 0;
                for (int n = 0; n < 8; n++) begin
                    occ = sb[n].size() - ((push_ch == n) ? 1 : 0);
                    if (occ > 0) begin
                        exp_valid[n] = 1'b1;
                        exp_cnt++;
                    end
                end
                checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
                checkOutput("count", 32'(count), 32'(exp_cnt));
                exp_ready = !exp_valid[in_sel] || out_ack[in_sel];
                checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
                for (int n = 0; n < 8; n++) begin
                    if (exp_valid[n]) begin
                        checkOutput($sformatf("out%0d", n), 32'(outs[n]), 32'(sb[n][0]));
                        if (out_ack[n]) begin
                            void'(sb[n].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sel   = 3'd0;
        in_data  = 16'h0000;
        out_ack  = 8'h00;
        repeat (2) @(negedge clk);
        #2;
        checkResetState("reset");
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #1;
            checkOutput("reset_in_ready", 32'(in_ready), 32'h1);
        end
        in_sel = 3'd0;
        clearModel();
        reset  = 1'b0;
        mon_en = 1'b1;

        // Fill every channel on consecutive cycles, then probe in_ready for every select.
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b1, 3'(n), 16'h1000 + 16'(n), 8'h00);
        end
        idleCycle();
        checkOutput("fill_valid", 32'(out_valid), 32'hFF);
        checkOutput("fill_count", 32'(count), 32'd8);
        for (int s = 0; s < 8; s++) begin
            applyStimulus(1'b0, 3'(s), 16'h0000, 8'h00);
            #1;
            checkOutput($sformatf("fill_ready%0d", s), 32'(in_ready), 32'h0);
        end

        // Backpressure on channel 3.
        applyStimulus(1'b1, 3'd3, 16'hAAAA, 8'h08);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 3'd3, 16'h5555, 8'h00);
            #1;
            checkOutput("bp_ready", 32'(in_ready), 32'h0);
            checkOutput("bp_out3", 32'(out3), 32'hAAAA);
        end
        applyStimulus(1'b1, 3'd3, 16'h5555, 8'h08);
        idleCycle();
        checkOutput("bp_out3_new", 32'(out3), 32'h5555);
        checkOutput("bp_count", 32'(count), 32'd8);

        // Ack channel 5 while full, then again while empty.
        applyStimulus(1'b0, 3'd0, 16'h0000, 8'h20);
        idleCycle();
        checkOutput("ack5_count", 32'(count), 32'd7);
        checkOutput("ack5_valid", 32'(out_valid), 32'hDF);
        checkOutput("ack5_hold", 32'(out5), 32'h1005);
        applyStimulus(1'b0, 3'd0, 16'h0000, 8'h20);
        idleCycle();
        checkOutput("ack5_again_count", 32'(count), 32'd7);
        checkOutput("ack5_again_hold", 32'(out5), 32'h1005);

        // Empty channel 2, then write it while acking 0 and 7 in the same cycle.
        applyStimulus(1'b0, 3'd0, 16'h0000, 8'h04);
        applyStimulus(1'b1, 3'd2, 16'hBEEF, 8'h81);
        idleCycle();
        checkOutput("simul_valid", 32'(out_valid), 32'h5E);
        checkOutput("simul_count", 32'(count), 32'd5);
        checkOutput("simul_out2", 32'(out2), 32'hBEEF);

        // Bring count to 6, then reset asynchronously with a transfer presented.
        applyStimulus(1'b1, 3'd0, 16'h0C0C, 8'h00);
        idleCycle();
        checkOutput("pre_reset_count", 32'(count), 32'd6);
        @(negedge clk);
        #1;
        mon_en   = 1'b0;
        push_ch  = -1;
        in_valid = 1'b1;
        in_sel   = 3'd5;
        in_data  = 16'hDEAD;
        out_ack  = 8'h00;
        #1;
        reset = 1'b1;
        #1;
        checkResetState("async");
        @(negedge clk);
        #1;
        checkResetState("held");
        in_valid = 1'b0;
        clearModel();
        reset  = 1'b0;
        mon_en = 1'b1;

        // Random soak; sparse acks keep channels busy so backpressure is exercised.
        for (int k = 0; k < 10000; k++) begin
            applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                          16'($urandom), 8'($urandom & $urandom));
        end
        applyStimulus(1'b0, 3'd0, 16'h0000, 8'hFF);
        idleCycle();
        checkOutput("drain_count", 32'(count), 32'd0);
        checkOutput("drain_valid", 32'(out_valid), 32'h0);
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
